matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_loader_pkg.sv | 37 +++
 rtl/ml_sram_wr_port.sv | 58 +++++
 rtl/matrix_loader.sv | 207 ++++++++++++++++++++
 tb/tb_matrix_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_loader_pkg.sv
// Shared types and constants for matrix_loader: FSM state encoding, header
// field positions and element-count helpers.
package matrix_loader_pkg;

  typedef enum logic [2:0] {
    IN_HDR    = 3'd0,
    IN_DATA   = 3'd1,
    W_HDR     = 3'd2,
    W_DATA    = 3'd3,
    KICK      = 3'd4,
    WAIT_BUSY = 3'd5,
    WAIT_DONE = 3'd6
  } ml_state_e;

  localparam int unsigned HDR_W        = 32;
  localparam int unsigned HDR_FIELD_W  = 16;
  localparam int unsigned HDR_ROWS_MSB = 31;
  localparam int unsigned HDR_ROWS_LSB = 16;
  localparam int unsigned HDR_COLS_MSB = 15;
  localparam int unsigned HDR_COLS_LSB = 0;
  localparam int unsigned COUNT_W      = 32;

  // rows*cols as a full 32-bit product of the two 16-bit header fields
  function automatic logic [COUNT_W-1:0] hdr_elem_count(input logic [HDR_W-1:0] hdr);
    logic [HDR_FIELD_W-1:0] rows;
    logic [HDR_FIELD_W-1:0] cols;
    rows = hdr[HDR_ROWS_MSB:HDR_ROWS_LSB];
    cols = hdr[HDR_COLS_MSB:HDR_COLS_LSB];
    return COUNT_W'(rows) * COUNT_W'(cols);
  endfunction

  // Largest element count that still fits behind the header word (2**addr_w - 1)
  function automatic logic [COUNT_W:0] max_elem_count(input int unsigned addr_w);
    return (33'd1 << addr_w) - 33'd1;
  endfunction

endpackage

// File: rtl/ml_sram_wr_port.sv
// One SRAM write port: word-address counter, remaining-element counter and
// same-cycle write drive for header/element beats.
module ml_sram_wr_port
  import matrix_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hdr_i,
  input  logic               elem_i,
  input  logic [COUNT_W-1:0] count_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               last_o,
  output logic               we_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [DATA_W-1:0]  wdata_o
);

  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_d;
  logic [COUNT_W-1:0] rem_q;
  logic [COUNT_W-1:0] rem_d;

  // Header restarts the port at address 1; each element advances by one
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (hdr_i) begin
      addr_d = ADDR_W'(1);
      rem_d  = count_i;
    end else if (elem_i) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - COUNT_W'(1);
    end else begin
      addr_d = addr_q;
      rem_d  = rem_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign last_o  = (rem_q == COUNT_W'(1));
  assign we_o    = hdr_i | elem_i;
  assign addr_o  = hdr_i ? '0 : addr_q;
  assign wdata_o = data_i;

endmodule

// File: rtl/matrix_loader.sv
// Streams an input matrix and a weight matrix into two SRAMs, then kicks the
// compute core and waits for it. Optional MATRIX_LOADER_DIMCHECK_EN rejects
// weight headers whose rows differ from the input cols.
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              dut__tb__sram_input_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_input_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_input_write_data,
  output logic              dut__tb__sram_weight_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_weight_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_weight_write_data,
  output logic              dut_valid,
  input  logic              dut_ready,
  output logic              done,
  output logic              load_error
);

  localparam logic [COUNT_W:0] MAX_COUNT = max_elem_count(ADDR_W);

  ml_state_e          state_q;
  ml_state_e          state_d;
  logic               ready_en_q;
  logic               load_error_q;
  logic               load_error_d;
  logic               load_state_s;
  logic               accept_s;
  logic [COUNT_W-1:0] hdr_count_s;
  logic               count_ok_s;
  logic               count_zero_s;
  logic               dim_ok_s;
  logic               in_hdr_s;
  logic               in_elem_s;
  logic               w_hdr_s;
  logic               w_elem_s;
  logic               in_last_s;
  logic               w_last_s;
  logic               dut_valid_s;
  logic               done_s;

  assign load_state_s = (state_q == IN_HDR) || (state_q == IN_DATA) ||
                        (state_q == W_HDR)  || (state_q == W_DATA);
  assign load_ready   = ready_en_q && load_state_s;
  assign accept_s     = load_valid && load_ready;
  assign hdr_count_s  = hdr_elem_count(load_data[HDR_W-1:0]);
  assign count_ok_s   = ({1'b0, hdr_count_s} <= MAX_COUNT);
  assign count_zero_s = (hdr_count_s == '0);

`ifdef MATRIX_LOADER_DIMCHECK_EN
  logic [HDR_FIELD_W-1:0] in_cols_q;

  // Remember input cols for the weight-header rows comparison
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_cols_q <= '0;
    end else if (in_hdr_s) begin
      in_cols_q <= load_data[HDR_COLS_MSB:HDR_COLS_LSB];
    end else begin
      in_cols_q <= in_cols_q;
    end
  end

  assign dim_ok_s = (load_data[HDR_ROWS_MSB:HDR_ROWS_LSB] == in_cols_q);
`else
  assign dim_ok_s = 1'b1;
`endif

  // Next-state and per-beat strobes
  always_comb begin
    state_d      = state_q;
    load_error_d = load_error_q;
    in_hdr_s     = 1'b0;
    in_elem_s    = 1'b0;
    w_hdr_s      = 1'b0;
    w_elem_s     = 1'b0;
    dut_valid_s  = 1'b0;
    done_s       = 1'b0;
    case (state_q)
      IN_HDR: begin
        if (accept_s) begin
          in_hdr_s     = 1'b1;
          load_error_d = !count_ok_s;
          if (!count_ok_s) begin
            state_d = IN_HDR;
          end else if (count_zero_s) begin
            state_d = W_HDR;
          end else begin
            state_d = IN_DATA;
          end
        end else begin
          state_d = IN_HDR;
        end
      end
      IN_DATA: begin
        if (accept_s) begin
          in_elem_s = 1'b1;
          state_d   = in_last_s ? W_HDR : IN_DATA;
        end else begin
          state_d = IN_DATA;
        end
      end
      W_HDR: begin
        if (accept_s) begin
          w_hdr_s = 1'b1;
          // The header is written even when it is rejected
          if (!count_ok_s || !dim_ok_s) begin
            load_error_d = 1'b1;
            state_d      = IN_HDR;
          end else begin
            load_error_d = 1'b0;
            state_d      = count_zero_s ? KICK : W_DATA;
          end
        end else begin
          state_d = W_HDR;
        end
      end
      W_DATA: begin
        if (accept_s) begin
          w_elem_s = 1'b1;
          state_d  = w_last_s ? KICK : W_DATA;
        end else begin
          state_d = W_DATA;
        end
      end
      KICK: begin
        dut_valid_s = 1'b1;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!dut_ready) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (dut_ready) begin
          done_s  = 1'b1;
          state_d = IN_HDR;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IN_HDR;
      end
    endcase
  end

  // State, sticky error and post-reset ready enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IN_HDR;
      load_error_q <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_error_q <= load_error_d;
      ready_en_q   <= 1'b1;
    end
  end

  assign dut_valid  = dut_valid_s;
  assign done       = done_s;
  assign load_error = load_error_q;

  ml_sram_wr_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_input_port (
    .clk     (clk),
    .reset_n (reset_n),
    .hdr_i   (in_hdr_s),
    .elem_i  (in_elem_s),
    .count_i (hdr_count_s),
    .data_i  (load_data),
    .last_o  (in_last_s),
    .we_o    (dut__tb__sram_input_write_enable),
    .addr_o  (dut__tb__sram_input_write_address),
    .wdata_o (dut__tb__sram_input_write_data)
  );

  ml_sram_wr_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_weight_port (
    .clk     (clk),
    .reset_n (reset_n),
    .hdr_i   (w_hdr_s),
    .elem_i  (w_elem_s),
    .count_i (hdr_count_s),
    .data_i  (load_data),
    .last_o  (w_last_s),
    .we_o    (dut__tb__sram_weight_write_enable),
    .addr_o  (dut__tb__sram_weight_write_address),
    .wdata_o (dut__tb__sram_weight_write_data)
  );

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader with a scripted compute-core
// dut_ready model and a write log per SRAM port.
module tb_matrix_loader;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef logic [47:0] ent_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              dut_ready = 1'b1;
  logic              load_ready;
  logic              in_we, w_we;
  logic [ADDR_W-1:0] in_addr, w_addr;
  logic [DATA_W-1:0] in_wdata, w_wdata;
  logic              dut_valid, done, load_error;

  int n_checks = 0;
  int n_errors = 0;
  int dv_cnt = 0;
  int done_cnt = 0;
  int done_bad = 0;
  int ready_bad = 0;
  logic prev_ready = 1'b1;
  logic in_compute = 1'b0;

  ent_t in_log[$];
  ent_t w_log[$];
  ent_t exp_in[$];
  ent_t exp_w[$];

  matrix_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                                (clk),
    .reset_n                            (reset_n),
    .load_valid                         (load_valid),
    .load_ready                         (load_ready),
    .load_data                          (load_data),
    .dut__tb__sram_input_write_enable   (in_we),
    .dut__tb__sram_input_write_address  (in_addr),
    .dut__tb__sram_input_write_data     (in_wdata),
    .dut__tb__sram_weight_write_enable  (w_we),
    .dut__tb__sram_weight_write_address (w_addr),
    .dut__tb__sram_weight_write_data    (w_wdata),
    .dut_valid                          (dut_valid),
    .dut_ready                          (dut_ready),
    .done                               (done),
    .load_error                         (load_error)
  );

  always #5 clk = ~clk;

  // Write logs and handshake bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    if (in_we) in_log.push_back({in_addr, in_wdata});
    if (w_we) w_log.push_back({w_addr, w_wdata});
    if (!reset_n) begin
      in_compute <= 1'b0;
    end else begin
      if (dut_valid) begin
        dv_cnt     <= dv_cnt + 1;
        in_compute <= 1'b1;
      end
      if ((dut_valid || in_compute) && load_ready) ready_bad <= ready_bad + 1;
      if (done) begin
        done_cnt   <= done_cnt + 1;
        in_compute <= 1'b0;
        if (!dut_ready || prev_ready) done_bad <= done_bad + 1;
      end
    end
    prev_ready <= dut_ready;
  end

  // Compute core: busy 3 cycles after the kick, idle again 20 cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (dut_valid) begin
        repeat (3) @(posedge clk);
        #1 dut_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 dut_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int elem_n(input logic [31:0] h);
    return int'(h[31:16]) * int'(h[15:0]);
  endfunction

  task automatic add_exp(input bit is_w, input logic [31:0] hdr, input logic [31:0] base);
    if (is_w) exp_w.push_back({16'h0000, hdr});
    else exp_in.push_back({16'h0000, hdr});
    for (int i = 0; i < elem_n(hdr); i++) begin
      if (is_w) exp_w.push_back({16'(i + 1), base + 32'(i)});
      else exp_in.push_back({16'(i + 1), base + 32'(i)});
    end
  endtask

  task automatic clear_logs();
    in_log.delete();
    w_log.delete();
    exp_in.delete();
    exp_w.delete();
  endtask

  task automatic check_logs(input string tag);
    check($sformatf("%s_in_n", tag), 64'(in_log.size()), 64'(exp_in.size()));
    for (int i = 0; i < in_log.size() && i < exp_in.size(); i++)
      check($sformatf("%s_in%0d", tag, i), 64'(in_log[i]), 64'(exp_in[i]));
    check($sformatf("%s_w_n", tag), 64'(w_log.size()), 64'(exp_w.size()));
    for (int i = 0; i < w_log.size() && i < exp_w.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(w_log[i]), 64'(exp_w[i]));
  endtask

  // Present one word and hold it until accepted (bounded)
  task automatic send_word(input logic [31:0] w, input bit gaps);
    bit ok;
    int k;
    if (gaps) begin
      k = 0;
      while (k < 6 && $urandom_range(1, 0) == 1) begin
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        k++;
      end
    end
    load_valid = 1'b1;
    load_data  = w;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (load_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    load_valid = 1'b0;
    check("send_accept", 64'(ok), 64'(1));
  endtask

  task automatic load_pair(input logic [31:0] ih, input logic [31:0] ib,
                           input logic [31:0] wh, input logic [31:0] wb, input bit gaps);
    add_exp(1'b0, ih, ib);
    add_exp(1'b1, wh, wb);
    send_word(ih, gaps);
    for (int i = 0; i < elem_n(ih); i++) send_word(ib + 32'(i), gaps);
    send_word(wh, gaps);
    for (int i = 0; i < elem_n(wh); i++) send_word(wb + 32'(i), gaps);
  endtask

  task automatic wait_done(input string tag);
    int start;
    bit seen;
    start = done_cnt;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(posedge clk);
      if (done_cnt > start) seen = 1'b1;
    end
    #1;
    check(tag, 64'(seen), 64'(1));
  endtask

  initial begin
    int dv0;

    // Reset values
    #1;
    check("rst_load_ready", 64'(load_ready), 64'(0));
    check("rst_in_we", 64'(in_we), 64'(0));
    check("rst_w_we", 64'(w_we), 64'(0));
    check("rst_dut_valid", 64'(dut_valid), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_load_error", 64'(load_error), 64'(0));
    #11 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_load_ready", 64'(load_ready), 64'(1));

    // 2x3 input, 3x2 weight, scripted compute
    clear_logs();
    dv0 = dv_cnt;
    load_pair(32'h0002_0003, 32'h0000_0100, 32'h0003_0002, 32'h0000_0200, 1'b0);
    wait_done("done_2x3");
    check_logs("t2x3");
    check("t2x3_dut_valid_cnt", 64'(dv_cnt - dv0), 64'(1));

    // 2x2/2x2 without and with random valid gaps
    clear_logs();
    load_pair(32'h0002_0002, 32'h0000_0300, 32'h0002_0002, 32'h0000_0400, 1'b0);
    wait_done("done_nogap");
    check_logs("nogap");
    clear_logs();
    load_pair(32'h0002_0002, 32'h0000_0300, 32'h0002_0002, 32'h0000_0400, 1'b1);
    wait_done("done_gap");
    check_logs("gap");

    // Zero-row input, then a header presented during compute is held
    clear_logs();
    dv0 = dv_cnt;
    add_exp(1'b0, 32'h0000_0005, 32'h0);
    add_exp(1'b1, 32'h0005_0001, 32'h0000_0501);
    send_word(32'h0000_0005, 1'b0);
    send_word(32'h0005_0001, 1'b0);
    for (int i = 0; i < 5; i++) send_word(32'h0000_0501 + 32'(i), 1'b0);
    load_pair(32'h0001_0001, 32'h0000_0600, 32'h0001_0001, 32'h0000_0700, 1'b0);
    wait_done("done_held");
    check_logs("zero_rows");
    check("held_dut_valid_cnt", 64'(dv_cnt - dv0), 64'(2));

    // Element count overflow, then the next header clears the error
    clear_logs();
    dv0 = dv_cnt;
    exp_in.push_back({16'h0000, 32'h0100_0100});
    send_word(32'h0100_0100, 1'b0);
    check("ovf_load_error", 64'(load_error), 64'(1));
    check("ovf_load_ready", 64'(load_ready), 64'(1));
    add_exp(1'b0, 32'h0001_0001, 32'h0000_0800);
    add_exp(1'b1, 32'h0001_0001, 32'h0000_0900);
    send_word(32'h0001_0001, 1'b0);
    check("ovf_err_cleared", 64'(load_error), 64'(0));
    send_word(32'h0000_0800, 1'b0);
    send_word(32'h0001_0001, 1'b0);
    send_word(32'h0000_0900, 1'b0);
    wait_done("done_after_ovf");
    check_logs("ovf");
    check("ovf_dut_valid_cnt", 64'(dv_cnt - dv0), 64'(1));

    // Largest legal count, abandoned by reset at element 4
    clear_logs();
    send_word(32'h0001_FFFF, 1'b0);
    check("max_count_no_error", 64'(load_error), 64'(0));
    check("max_count_ready", 64'(load_ready), 64'(1));
    exp_in.push_back({16'h0000, 32'h0001_FFFF});
    for (int i = 0; i < 3; i++) begin
      send_word(32'h0000_0C00 + 32'(i), 1'b0);
      exp_in.push_back({16'(i + 1), 32'h0000_0C00 + 32'(i)});
    end
    check_logs("pre_rst");
    load_valid = 1'b1;
    load_data  = 32'h0000_0C03;
    #1;
    check("elem4_we", 64'(in_we), 64'(1));
    check("elem4_addr", 64'(in_addr), 64'(4));
    reset_n = 1'b0;
    #1;
    check("midrst_load_ready", 64'(load_ready), 64'(0));
    check("midrst_in_we", 64'(in_we), 64'(0));
    check("midrst_dut_valid", 64'(dut_valid), 64'(0));
    check("midrst_load_error", 64'(load_error), 64'(0));
    load_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    load_pair(32'h0001_0001, 32'h0000_0A00, 32'h0001_0001, 32'h0000_0B00, 1'b0);
    wait_done("done_after_rst");
    check_logs("fresh");

    // Weight rows differ from input cols
    clear_logs();
    dv0 = dv_cnt;
    add_exp(1'b0, 32'h0002_0003, 32'h0000_0D00);
    send_word(32'h0002_0003, 1'b0);
    for (int i = 0; i < 6; i++) send_word(32'h0000_0D00 + 32'(i), 1'b0);
`ifdef MATRIX_LOADER_DIMCHECK_EN
    exp_w.push_back({16'h0000, 32'h0002_0002});
    send_word(32'h0002_0002, 1'b0);
    check("dim_load_error", 64'(load_error), 64'(1));
    check("dim_load_ready", 64'(load_ready), 64'(1));
    repeat (30) @(posedge clk);
    #1;
    check("dim_no_dut_valid", 64'(dv_cnt - dv0), 64'(0));
    check_logs("dim");
`else
    add_exp(1'b1, 32'h0002_0002, 32'h0000_0E00);
    send_word(32'h0002_0002, 1'b0);
    for (int i = 0; i < 4; i++) send_word(32'h0000_0E00 + 32'(i), 1'b0);
    wait_done("done_dim_mismatch");
    check_logs("dim");
    check("dim_load_error", 64'(load_error), 64'(0));
    check("dim_dut_valid_cnt", 64'(dv_cnt - dv0), 64'(1));
`endif

    check("done_with_ready_rise", 64'(done_bad), 64'(0));
    check("no_ready_during_compute", 64'(ready_bad), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
